mips_data_memory_ctrl: RTL

Parametrised successor to the single-cycle data memory, for the multicycle and pipelined MIPS cores. It adds byte and halfword loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) with sign or zero extension, and configurable depth. It adds a REQ/READY handshake with programmable wait states to model slow memory. Misaligned accesses are detected and reported on ADDR_ERR instead of corrupting memory.

---
 rtl/mips_data_memory_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_data_memory_ctrl.sv
// Data memory controller for the multicycle / pipelined MIPS cores.
// Supports byte, halfword and word loads/stores with sign or zero extension,
// a REQ/READY handshake with WAIT_STATES programmable wait cycles, and
// reports misaligned or reserved-size accesses on ADDR_ERR without writing.
//
// Ports:
//   CLK      in   clock, all state updates on the rising edge
//   RST      in   synchronous active-high reset
//   REQ      in   request valid, accepted only while BUSY=0
//   WE       in   1 = store, 0 = load
//   SIZE     in   00 byte, 01 halfword, 10 word, 11 reserved (error)
//   SIGNED   in   loads only: 1 sign-extend, 0 zero-extend
//   A        in   byte address (aliases modulo 4*DEPTH)
//   WD       in   store data, right-justified
//   RD       out  registered load result, held until the next load/error response
//   READY    out  one-cycle response pulse
//   BUSY     out  request outstanding (acceptance edge through READY cycle)
//   ADDR_ERR out  qualifies READY: access was misaligned or reserved
module mips_data_memory_ctrl #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        READY,
    output logic        BUSY,
    output logic        ADDR_ERR
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] WaitInit = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic          we_q, sgn_q, err_q;
    logic [1:0]    size_q;
    logic [31:0]   wd_q;
    logic [31:0]   rd_q;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          req_err;
    logic [AW-1:0] op_idx;
    logic [1:0]    op_off;
    logic          op_we, op_sgn, op_err;
    logic [1:0]    op_size;
    logic [31:0]   op_wd;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   word;
    logic [31:0]   word_sh;
    logic [15:0]   half;
    logic [31:0]   load_val;
    logic          unused_a;

    assign unused_a = ^A[31:AW+2];

    assign accept = (state_q == StIdle) && REQ;

    always_comb begin
        req_err = 1'b0;
        case (SIZE)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = A[0];
            2'b10:   req_err = (A[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // With zero wait states the array access happens on the acceptance edge,
    // before the request fields are registered, so use the live inputs then.
    always_comb begin
        if (accept) begin
            op_idx  = A[AW+1:2];
            op_off  = A[1:0];
            op_we   = WE;
            op_size = SIZE;
            op_sgn  = SIGNED;
            op_wd   = WD;
            op_err  = req_err;
        end else begin
            op_idx  = idx_q;
            op_off  = off_q;
            op_we   = we_q;
            op_size = size_q;
            op_sgn  = sgn_q;
            op_wd   = wd_q;
            op_err  = err_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be    = 4'b0000;
        wlane = op_wd;
        case (op_size)
            2'b00: begin
                be    = 4'b0001 << op_off;
                wlane = {4{op_wd[7:0]}};
            end
            2'b01: begin
                be    = op_off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{op_wd[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign word    = mem[op_idx];
    assign word_sh = word >> {op_off, 3'b000};
    assign half    = op_off[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = word;
        case (op_size)
            2'b00:   load_val = op_sgn ? {{24{word_sh[7]}}, word_sh[7:0]}
                                       : {24'h000000, word_sh[7:0]};
            2'b01:   load_val = op_sgn ? {{16{half[15]}}, half} : {16'h0000, half};
            default: load_val = word;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            wd_q    <= 32'h0;
            err_q   <= 1'b0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q  <= A[AW+1:2];
                off_q  <= A[1:0];
                we_q   <= WE;
                size_q <= SIZE;
                sgn_q  <= SIGNED;
                wd_q   <= WD;
                err_q  <= req_err;
            end
            // RD only changes on load or error responses; stores leave it held
            if (commit && op_err) begin
                rd_q <= 32'h0;
            end else if (commit && !op_we) begin
                rd_q <= load_val;
            end
        end
    end

    // Array is not reset; reset only blocks a pending write
    always_ff @(posedge CLK) begin
        if (!RST && commit && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[op_idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    assign RD       = rd_q;
    assign READY    = (state_q == StResp);
    assign BUSY     = (state_q != StIdle);
    assign ADDR_ERR = (state_q == StResp) && err_q;

endmodule
